muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit owning the HI/LO register pair for the pipelined MIPS core.

---
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_muldiv_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine owning HI/LO for the MIPS core.
// One bit per cycle: radix-2 shift-add multiply, restoring divide, then a sign-fix cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             cancel,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic done_nxt, capture, iterate, fix_wr, mt_ok;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   areg, breg;
  logic               is_div, neg_q, neg_r, dz;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  // Operand capture: signed ops run on magnitudes, signs are reapplied at FIX.
  logic             sa_c, sb_c;
  logic [WIDTH-1:0] a_abs, b_abs;
  always_comb begin
    sa_c  = ~op[0] & srca[WIDTH-1];
    sb_c  = ~op[0] & srcb[WIDTH-1];
    a_abs = cond_neg(srca, sa_c);
    b_abs = cond_neg(srcb, sb_c);
  end

  // Iteration datapath; acc holds {upper, lower} for multiply, {remainder, quotient} for divide.
  logic [WIDTH:0] mul_sum, div_shift, div_diff;
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? areg : {WIDTH{1'b0}})};
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, breg};
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;
  always_comb begin
    prod = cond_neg2(acc, neg_q);
    if (!is_div) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (dz) begin
      res_hi = cond_neg(areg, neg_r);
      res_lo = {WIDTH{1'b1}};
    end else begin
      res_hi = cond_neg(acc[2*WIDTH-1:WIDTH], neg_r);
      res_lo = cond_neg(acc[WIDTH-1:0], neg_q);
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    capture   = 1'b0;
    iterate   = 1'b0;
    fix_wr    = 1'b0;
    mt_ok     = 1'b0;
    case (state)
      IDLE: begin
        mt_ok = ~start;
        if (start && !cancel) begin
          capture   = 1'b1;
          state_nxt = op[1] ? DIV : MUL;
        end
      end
      MUL, DIV: begin
        if (cancel) state_nxt = IDLE;
        else begin
          iterate = 1'b1;
          if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
        end
      end
      FIX: begin
        state_nxt = IDLE;
        if (!cancel) begin
          fix_wr   = 1'b1;
          done_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (capture)      cnt <= '0;
      else if (iterate) cnt <= cnt + CW'(1);
      if (fix_wr) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (mt_ok) begin
        if (wr_hi) hi <= wdata;
        if (wr_lo) lo <= wdata;
      end
    end
  end

  // Datapath registers carry no reset; they are always loaded at capture before use.
  always_ff @(posedge clk) begin
    if (capture) begin
      areg   <= a_abs;
      breg   <= b_abs;
      acc    <= {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
      is_div <= op[1];
      neg_q  <= sa_c ^ sb_c;
      neg_r  <= sa_c;
      dz     <= (srcb == '0);
    end else if (iterate) begin
      if (!is_div)          acc <= {mul_sum, acc[WIDTH-1:1]};
      else if (div_diff[WIDTH]) acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else                  acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized ops vs. a plain-arithmetic model.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset, start, cancel, wr_hi, wr_lo;
  logic [1:0]  op;
  logic [31:0] srca, srcb, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .cancel(cancel), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: MIPS mult/multu/div/divu semantics via 64-bit integer arithmetic.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    longint      sa, sb, p;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = '0;
    el = '0;
    case (o)
      2'd0: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      2'd1: begin u = {32'b0, a} * {32'b0, b}; eh = u[63:32]; el = u[31:0]; end
      default: begin
        if (b == 32'd0) begin
          eh = a; el = 32'hFFFFFFFF;
        end else if (o == 2'd2 && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          eh = 32'd0; el = 32'h80000000;
        end else if (o == 2'd2) begin
          p = sa / sb; el = p[31:0];
          p = sa % sb; eh = p[31:0];
        end else begin
          el = a / b; eh = a % b;
        end
      end
    endcase
  endtask

  // Issues one op, scrambles inputs after capture, waits (bounded) for done.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bcnt);
    op = o; srca = a; srcb = b; start = 1'b1;
    step();
    start = 1'b0; op = 2'($urandom); srca = $urandom; srcb = $urandom;
    lat = 0; bcnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bcnt++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; cancel = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = 2'd0; srca = '0; srcb = '0; wdata = '0;
    step(); step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_multu_max();
    int lat, bcnt;
    do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
    checks++; if (lat !== 33) begin errors++; $display("FAIL multu_latency: got %0d want 33", lat); end
    checks++; if (bcnt !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 33", bcnt); end
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", lo); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    do_op(2'd0, 32'hFFFFFFFD, 32'd5, lat, bcnt);
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_lo: got %h want fffffff1", lo); end
    do_op(2'd2, 32'hFFFFFFF9, 32'd2, lat, bcnt);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", lat); end
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", hi); end
    step();
  endtask

  task automatic test_div_corners();
    int lat, bcnt;
    do_op(2'd3, 32'd7, 32'd0, lat, bcnt);
    checks++; if (lat !== 33) begin errors++; $display("FAIL divz_latency: got %0d want 33", lat); end
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_lo: got %h want ffffffff", lo); end
    checks++; if (hi !== 32'h00000007) begin errors++; $display("FAIL divz_hi: got %h want 00000007", hi); end
    do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, lat, bcnt);
    checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL divovf_lo: got %h want 80000000", lo); end
    checks++; if (hi !== 32'h00000000) begin errors++; $display("FAIL divovf_hi: got %h want 00000000", hi); end
    step();
  endtask

  task automatic test_cancel();
    bit seen;
    wr_hi = 1'b1; wdata = 32'hAAAA0000; step();
    wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h0000BBBB; step();
    wr_lo = 1'b0;
    checks++; if (hi !== 32'hAAAA0000) begin errors++; $display("FAIL mthi: got %h want aaaa0000", hi); end
    checks++; if (lo !== 32'h0000BBBB) begin errors++; $display("FAIL mtlo: got %h want 0000bbbb", lo); end
    op = 2'd0; srca = 32'd5; srcb = 32'd7; start = 1'b1; step();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b want 1", busy); end
    repeat (9) step();
    cancel = 1'b1; step();
    cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b want 0", busy); end
    seen = 1'b0;
    repeat (40) begin if (done === 1'b1) seen = 1'b1; step(); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL cancel_done: got %b want 0", seen); end
    // cancel together with start in IDLE drops the start
    op = 2'd1; srca = 32'd3; srcb = 32'd3; start = 1'b1; cancel = 1'b1; step();
    start = 1'b0; cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_start_busy: got %b want 0", busy); end
    repeat (40) begin if (done === 1'b1) seen = 1'b1; step(); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL cancel_start_done: got %b want 0", seen); end
    checks++; if (hi !== 32'hAAAA0000) begin errors++; $display("FAIL cancel_hi: got %h want aaaa0000", hi); end
    checks++; if (lo !== 32'h0000BBBB) begin errors++; $display("FAIL cancel_lo: got %h want 0000bbbb", lo); end
  endtask

  task automatic test_ignore_while_busy();
    int lat;
    op = 2'd3; srca = 32'd100; srcb = 32'd7; start = 1'b1; step();
    start = 1'b0; lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (lat == 4) begin
        start = 1'b1; op = 2'd0; srca = 32'd9; srcb = 32'd3; wr_lo = 1'b1; wdata = 32'hDEADBEEF;
      end else begin
        start = 1'b0; wr_lo = 1'b0;
      end
      step();
      lat++;
    end
    checks++; if (lat !== 33) begin errors++; $display("FAIL busy_start_latency: got %0d want 33", lat); end
    checks++; if (lo !== 32'h0000000E) begin errors++; $display("FAIL busy_start_lo: got %h want 0000000e", lo); end
    checks++; if (hi !== 32'h00000002) begin errors++; $display("FAIL busy_start_hi: got %h want 00000002", hi); end
    step();
  endtask

  task automatic test_reset_mid_op();
    int lat, bcnt;
    op = 2'd0; srca = 32'd123; srcb = 32'd456; start = 1'b1; step();
    start = 1'b0;
    repeat (11) step();
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL midreset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL midreset_lo: got %h want 0", lo); end
    step();
    reset = 1'b0;
    step();
    do_op(2'd1, 32'd6, 32'd7, lat, bcnt);
    checks++; if (lat !== 33) begin errors++; $display("FAIL post_reset_latency: got %0d want 33", lat); end
    checks++; if (lo !== 32'h0000002A) begin errors++; $display("FAIL post_reset_lo: got %h want 0000002a", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL post_reset_hi: got %h want 0", hi); end
    step();
  endtask

  task automatic test_random();
    int lat, bcnt;
    logic [1:0]  o;
    logic [31:0] a, b, eh, el;
    for (int n = 0; n < 24; n++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 9);
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        3: a = $urandom_range(0, 50);
        default: ;
      endcase
      model(o, a, b, eh, el);
      do_op(o, a, b, lat, bcnt);
      checks++; if (lat !== 33) begin errors++; $display("FAIL rnd_latency op=%0d: got %0d want 33", o, lat); end
      checks++; if (hi !== eh) begin errors++; $display("FAIL rnd_hi op=%0d a=%h b=%h: got %h want %h", o, a, b, hi, eh); end
      checks++; if (lo !== el) begin errors++; $display("FAIL rnd_lo op=%0d a=%h b=%h: got %h want %h", o, a, b, lo, el); end
      if ($urandom_range(0, 1) == 1) step();
    end
    step();
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_back_to_back();
    test_div_corners();
    test_cancel();
    test_ignore_while_busy();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
